crypto_op_fsm: RTL
==================

Name: crypto_op_fsm

Overview:
Second-generation request sequencer for the crypto accelerator control group. It pops one instruction from the request queue and decodes its mode: SHA hash, AES encrypt, AES decrypt, or reserved. It then issues multi-beat command packets on the 8-bit data bus under arbiter control and waits for per-operation ACKs with a timeout. It posts a status word to the completion queue. Address width, timeout and ACK mapping are parametrised.

Parameters:
ADDRW, 16, address width in bits; must be a multiple of 8 and at least 8; ADDR_BYTES = ADDRW/8
TIMEOUT, 1024, maximum cycles spent in any ACK wait before aborting; at least 2
CNTW, $clog2(TIMEOUT+1), width of the timeout counter (derived; do not override)

Ports:
clk  in  1  clock, all logic on the rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  request queue has an instruction
req_data  in  3*ADDRW+2  {mode[1:0], key_addr, text_addr, dst_addr}; mode is in the MSBs
req_ready  out  1  one-cycle dequeue pulse to the request queue
cpl_valid  out  1  completion entry valid
cpl_ready  in  1  completion queue accepts the entry
cpl_status  out  2  00 OK, 01 BAD_MODE, 10 TIMEOUT
cpl_addr  out  ADDRW  dst_addr of the completed request
bus_req  out  1  bus arbiter request
bus_grant  in  1  bus arbiter grant
data_out  out  8  command beat
data_valid  out  1  data_out valid
data_ready  in  1  bus accepts the beat
ack_in  in  3  [0] memory read done, [1] compute done, [2] memory write done
busy  out  1  high whenever state is not IDLE

Behaviour:
- Reset (asynchronous, rst_n=0): state goes to IDLE. All outputs and internal registers go to 0.
- States: IDLE, REQ_BUS, SEND, WAIT_ACK, COMPLETE. A phase register selects the current command: RD_KEY, RD_TXT, OP, WR.
- IDLE with req_valid=1:
  - Pulse req_ready for that single cycle.
  - Latch all req_data fields.
  - Mode 11: go to COMPLETE with status BAD_MODE. The bus is never requested.
  - Mode 00 (SHA): first phase is RD_TXT; sequence RD_TXT, OP, WR.
  - Modes 01/10 (AES enc/dec): first phase is RD_KEY; sequence RD_KEY, RD_TXT, OP, WR.
  - Otherwise go to REQ_BUS.
- REQ_BUS: bus_req=1. On bus_grant=1, go to SEND and set beat index to 0.
- SEND:
  - bus_req=1; data_valid = bus_grant.
  - A beat transfers when data_valid=1 and data_ready=1.
  - Beat 0 is the header {cmd[3:0], 2'b00, mode[1:0]}. cmd values: RD_KEY=4'hA, RD_TXT=4'hB, OP=4'hC, WR=4'hD.
  - RD_KEY, RD_TXT and WR then send ADDR_BYTES address bytes, MSB first: key_addr, text_addr, dst_addr respectively. OP is header only.
  - data_out is held stable while data_valid=1 and data_ready=0.
  - If bus_grant drops mid-packet, data_valid goes low and the beat index is held. Resume from the same beat when the grant returns.
  - After the last beat transfers, go to WAIT_ACK with bus_req=0 in that cycle.
- WAIT_ACK:
  - Expected ACK: ack_in[0] for RD_KEY/RD_TXT, ack_in[1] for OP, ack_in[2] for WR. Non-matching ACK bits are ignored.
  - The timeout counter clears on entry and increments every cycle.
  - Expected ACK seen: advance phase and go to REQ_BUS, or to COMPLETE with OK after WR.
  - Counter reaches TIMEOUT-1 with no ACK: go to COMPLETE with TIMEOUT. An ACK in that same cycle wins (OK path).
- COMPLETE:
  - Hold cpl_valid=1 with stable cpl_status and cpl_addr until cpl_ready=1, then go to IDLE.
  - A new request is not accepted in the cycle cpl_ready is seen; req_ready is never asserted outside IDLE.
- Latency, zero-wait bus and immediate grant: IDLE to first data_valid is 2 cycles.
- Reset mid-operation: abandon the operation immediately and drop bus_req/data_valid. No completion is posted.

Decomposition:
- Package crypto_ctrl_pkg holds:
  - state_t and phase_t enums
  - cmd constants (A/B/C/D)
  - mode constants
  - status constants
  - ACK bit index localparams
- Sub-module cmd_packetizer holds the beat counter, header/address byte mux and the data_valid/data_ready/grant-stall handling. It is driven by start/cmd/addr and returns done.

Test Plan:
1. ADDRW=16, SHA request mode=00, text=0x1234, dst=0x5678; grant, ready and ACKs prompt -> beats B0,12,34 / C0 / D0,56,78; cpl_status=00, cpl_addr=0x5678; req_ready pulsed exactly once.
2. AES enc mode=01, key=0xAA55 -> first packet A1,AA,55; 4 packets total; OP header is C1; status OK.
3. Mode=11 -> req_ready pulse, then cpl_valid with status 01; bus_req never asserted.
4. TIMEOUT=8, ack_in[1] never arrives in OP -> exactly 8 cycles in WAIT_ACK, then cpl_status=10; WR packet never sent.
5. Drop bus_grant after beat 1 of an RD_TXT packet for 3 cycles; hold data_ready=0 for 2 cycles on beat 2 -> no beat lost or repeated; data_out stable throughout the stalls.
6. cpl_ready held low 5 cycles with req_valid=1 -> cpl_valid is held, no new dequeue; rst_n pulsed low mid-WAIT_ACK -> all outputs 0 immediately, returns to IDLE.

Source files
------------

// File: rtl/crypto_ctrl_pkg.sv
// Shared types and encodings for the crypto request sequencer.
// Covers states, command phases, command bytes, modes, status and ACK lanes.
package crypto_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ_BUS,
    S_SEND,
    S_WAIT_ACK,
    S_COMPLETE
  } state_t;

  typedef enum logic [1:0] {
    PH_RD_KEY,
    PH_RD_TXT,
    PH_OP,
    PH_WR
  } phase_t;

  localparam logic [3:0] CMD_RD_KEY = 4'hA;
  localparam logic [3:0] CMD_RD_TXT = 4'hB;
  localparam logic [3:0] CMD_OP     = 4'hC;
  localparam logic [3:0] CMD_WR     = 4'hD;

  localparam logic [1:0] MODE_SHA     = 2'b00;
  localparam logic [1:0] MODE_AES_ENC = 2'b01;
  localparam logic [1:0] MODE_AES_DEC = 2'b10;
  localparam logic [1:0] MODE_RSVD    = 2'b11;

  localparam logic [1:0] ST_OK       = 2'b00;
  localparam logic [1:0] ST_BAD_MODE = 2'b01;
  localparam logic [1:0] ST_TIMEOUT  = 2'b10;

  localparam logic [1:0] ACK_RD = 2'd0;
  localparam logic [1:0] ACK_OP = 2'd1;
  localparam logic [1:0] ACK_WR = 2'd2;

  function automatic logic [3:0] cmd_of(phase_t p);
    logic [3:0] c;
    unique case (p)
      PH_RD_KEY: c = CMD_RD_KEY;
      PH_RD_TXT: c = CMD_RD_TXT;
      PH_OP:     c = CMD_OP;
      PH_WR:     c = CMD_WR;
    endcase
    return c;
  endfunction

  function automatic logic [1:0] ack_of(phase_t p);
    logic [1:0] a;
    unique case (p)
      PH_RD_KEY: a = ACK_RD;
      PH_RD_TXT: a = ACK_RD;
      PH_OP:     a = ACK_OP;
      PH_WR:     a = ACK_WR;
    endcase
    return a;
  endfunction

endpackage

// File: rtl/cmd_packetizer.sv
// Serialises one command packet: header beat then optional address bytes.
// Beat index holds across grant drops and data_ready stalls.
module cmd_packetizer
  import crypto_ctrl_pkg::*;
#(
  parameter int ADDRW = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             active,
  input  logic             grant,
  input  logic             data_ready,
  input  logic [3:0]       cmd,
  input  logic [1:0]       mode,
  input  logic [ADDRW-1:0] addr,
  input  logic             hdr_only,
  output logic [7:0]       data_out,
  output logic             data_valid,
  output logic             done
);

  localparam int AB = ADDRW / 8;
  localparam int BW = $clog2(AB + 1);

  logic [BW-1:0] beat;
  logic [BW-1:0] last;
  logic          xfer;

  assign last       = hdr_only ? '0 : BW'(AB);
  assign data_valid = active & grant;
  assign xfer       = data_valid & data_ready;
  assign done       = xfer & (beat == last);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat <= '0;
    end else if (start) begin
      beat <= '0;
    end else if (xfer && !done) begin
      beat <= beat + BW'(1);
    end
  end

  // Address bytes go out MSB first after the header.
  always_comb begin
    data_out = '0;
    if (active) begin
      data_out = {cmd, 2'b00, mode};
      for (int i = 1; i <= AB; i++) begin
        if (beat == BW'(i)) data_out = addr[ADDRW-8*i +: 8];
      end
    end
  end

endmodule

// File: rtl/crypto_op_fsm.sv
// Crypto request sequencer: dequeue, issue command packets, await ACKs,
// and post a completion status word.
module crypto_op_fsm
  import crypto_ctrl_pkg::*;
#(
  parameter int ADDRW   = 16,
  parameter int TIMEOUT = 1024,
  parameter int CNTW    = $clog2(TIMEOUT + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_valid,
  input  logic [3*ADDRW+1:0] req_data,
  output logic               req_ready,
  output logic               cpl_valid,
  input  logic               cpl_ready,
  output logic [1:0]         cpl_status,
  output logic [ADDRW-1:0]   cpl_addr,
  output logic               bus_req,
  input  logic               bus_grant,
  output logic [7:0]         data_out,
  output logic               data_valid,
  input  logic               data_ready,
  input  logic [2:0]         ack_in,
  output logic               busy
);

  state_t           state, state_d;
  phase_t           phase, phase_d;
  logic [1:0]       status, status_d;
  logic [CNTW-1:0]  cnt, cnt_d;
  logic [1:0]       mode_q;
  logic [ADDRW-1:0] key_q, text_q, dst_q;
  logic [ADDRW-1:0] pkt_addr;
  logic [1:0]       req_mode;
  logic             accept, start, done;

  assign req_mode = req_data[3*ADDRW +: 2];
  assign accept   = (state == S_IDLE) & req_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      phase  <= PH_RD_KEY;
      status <= ST_OK;
      cnt    <= '0;
    end else begin
      state  <= state_d;
      phase  <= phase_d;
      status <= status_d;
      cnt    <= cnt_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q <= '0;
      key_q  <= '0;
      text_q <= '0;
      dst_q  <= '0;
    end else if (accept) begin
      mode_q <= req_mode;
      key_q  <= req_data[2*ADDRW +: ADDRW];
      text_q <= req_data[ADDRW +: ADDRW];
      dst_q  <= req_data[0 +: ADDRW];
    end
  end

  always_comb begin
    state_d   = state;
    phase_d   = phase;
    status_d  = status;
    cnt_d     = cnt;
    req_ready = 1'b0;
    start     = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (req_valid) begin
          req_ready = 1'b1;
          status_d  = ST_OK;
          if (req_mode == MODE_RSVD) begin
            status_d = ST_BAD_MODE;
            state_d  = S_COMPLETE;
          end else begin
            phase_d = (req_mode == MODE_SHA) ? PH_RD_TXT : PH_RD_KEY;
            state_d = S_REQ_BUS;
          end
        end
      end
      S_REQ_BUS: begin
        if (bus_grant) begin
          start   = 1'b1;
          state_d = S_SEND;
        end
      end
      S_SEND: begin
        if (done) begin
          cnt_d   = '0;
          state_d = S_WAIT_ACK;
        end
      end
      S_WAIT_ACK: begin
        cnt_d = cnt + CNTW'(1);
        // A matching ACK on the final count still takes the OK path.
        if (ack_in[ack_of(phase)]) begin
          if (phase == PH_WR) begin
            status_d = ST_OK;
            state_d  = S_COMPLETE;
          end else begin
            phase_d = phase_t'(phase + 2'd1);
            state_d = S_REQ_BUS;
          end
        end else if (cnt == CNTW'(TIMEOUT - 1)) begin
          status_d = ST_TIMEOUT;
          state_d  = S_COMPLETE;
        end
      end
      S_COMPLETE: begin
        if (cpl_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    unique case (phase)
      PH_RD_KEY: pkt_addr = key_q;
      PH_RD_TXT: pkt_addr = text_q;
      default:   pkt_addr = dst_q;
    endcase
  end

  cmd_packetizer #(.ADDRW(ADDRW)) u_pkt (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .active     (state == S_SEND),
    .grant      (bus_grant),
    .data_ready (data_ready),
    .cmd        (cmd_of(phase)),
    .mode       (mode_q),
    .addr       (pkt_addr),
    .hdr_only   (phase == PH_OP),
    .data_out   (data_out),
    .data_valid (data_valid),
    .done       (done)
  );

  assign bus_req    = (state == S_REQ_BUS) | (state == S_SEND);
  assign busy       = (state != S_IDLE);
  assign cpl_valid  = (state == S_COMPLETE);
  assign cpl_status = cpl_valid ? status : '0;
  assign cpl_addr   = cpl_valid ? dst_q : '0;

endmodule
